mul_seq_nbit: RTL and testbench
===============================

Name: mul_seq_nbit

Overview:
- Parametrised iterative shift-add multiplier for the FIR datapath. It is the sequential successor to the combinational n-bit multiplier.
- Processes BITS_PER_CYCLE multiplier bits per clock, so area and latency can be traded.
- Supports signed (two's complement) and unsigned operands.
- Uses valid/ready handshakes on input and output, so it can sit between FIR tap storage and the accumulator under backpressure.

Parameters:
- DATA_WIDTH, 16: operand width N. Must be ≥ 2 and divisible by BITS_PER_CYCLE.
- BITS_PER_CYCLE, 1: multiplier bits consumed per BUSY cycle. Legal values are 1, 2, 4. Latency L = DATA_WIDTH/BITS_PER_CYCLE.

Ports:
- clk_i  input  1  single clock, rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- in_valid_i  input  1  operands and mode are valid.
- in_ready_o  output  1  block can accept operands.
- signed_i  input  1  1 = operands are two's complement; 0 = unsigned.
- a_i  input  DATA_WIDTH  multiplicand.
- b_i  input  DATA_WIDTH  multiplier.
- out_valid_o  output  1  product is valid.
- out_ready_i  input  1  consumer accepts the product.
- p_o  output  2*DATA_WIDTH  product (signed or unsigned per the captured mode).
- busy_o  output  1  a multiplication is in progress (state BUSY).

Behaviour:
- Reset (async assert, sync release):
  - State goes to IDLE.
  - in_ready_o=1, out_valid_o=0, busy_o=0, p_o=0.
  - Internal accumulator, counter and operand registers are cleared.
  - Reset mid-operation abandons the operation; nothing is output.
- States:
  - IDLE: in_ready_o=1. On in_valid_i&&in_ready_o, capture a_i, b_i and signed_i, clear the accumulator, set counter=0, go to BUSY. Otherwise stay in IDLE.
  - BUSY: in_ready_o=0, busy_o=1. Each edge adds (|a| × next BITS_PER_CYCLE bits of |b|) shifted into the accumulator, and increments the counter. When counter reaches L-1, that edge completes the product, applies sign correction, loads p_o and goes to DONE.
  - DONE: out_valid_o=1, in_ready_o=0. p_o is held stable while out_ready_i=0. On out_valid_o&&out_ready_i, go to IDLE, deassert out_valid_o and keep p_o at its last value.
- Latency:
  - Operands accepted at edge T0 give out_valid_o=1 after edge T0+L.
  - Example: N=16, BPC=1 gives 16 edges. N=16, BPC=4 gives 4 edges.
  - Minimum issue interval is L+2 cycles (accept, L BUSY edges, handshake, IDLE).
- Input handshake rules:
  - in_valid_i is ignored in BUSY and DONE.
  - a_i, b_i and signed_i are sampled only at the accept edge; later input changes have no effect.
- Arithmetic:
  - signed_i=1: compute the magnitudes of a and b in N bits, unsigned. −2^(N−1) has magnitude 2^(N−1), which fits. Multiply, then negate the 2N-bit result if sign(a)^sign(b).
  - signed_i=0: plain unsigned product.
  - The result is always exact in 2N bits. No overflow or truncation is possible.
- Boundaries:
  - A zero operand still takes the full L cycles. There is no early termination, so latency is deterministic.
  - Signed −2^(N−1) × −2^(N−1) = +2^(2N−2).
  - out_ready_i held high in DONE gives a 1-cycle DONE.
  - out_ready_i asserted outside DONE has no effect.

Test Plan:
- N=8, BPC=1, unsigned 0xFF×0xFF → p_o=0xFE01; out_valid_o rises exactly 8 edges after accept; busy_o high for those 8 cycles.
- N=8, signed_i=1:
  - 0xFF×0x02 → 0xFFFE.
  - 0x80×0x80 → 0x4000.
  - 0x80×0x7F → 0xC080.
  - Unsigned 0xFF×0x02 → 0x01FE.
- Backpressure:
  - Hold out_ready_i=0 for 5 cycles after out_valid_o: p_o stable, in_ready_o=0, and an in_valid_i pulse with new operands is ignored.
  - Then out_ready_i=1: return to IDLE, in_ready_o=1.
- Reset mid-op: assert rst_ni=0 at the 3rd BUSY cycle of 0x12×0x34.
  - All outputs are at reset values immediately.
  - After release, 0x03×0x05 → 0x000F with normal latency.
- Operand change during BUSY: change a_i and b_i every cycle after accept of 0x10×0x10 → p_o=0x0100.
- Parameter sweep: N=16 with BPC=1, 2 and 4.
  - 2000 random vectors per configuration, random mode, random out_ready_i.
  - Compare p_o against a behavioural signed/unsigned a×b model.
  - Check latency = 16, 8, 4 respectively.

Source files
------------

// File: rtl/mul_seq_nbit.sv
// mul_seq_nbit: iterative shift-add multiplier with valid/ready handshakes.
//
// Consumes BITS_PER_CYCLE multiplier bits per BUSY cycle, so one product takes
// L = DATA_WIDTH / BITS_PER_CYCLE BUSY cycles. Signed operands are reduced to
// magnitudes at capture time. The unsigned magnitude product is negated at the
// end if the operand signs differed.
//
// Ports:
//   clk_i        rising-edge clock
//   rst_ni       asynchronous active-low reset
//   in_valid_i   operands/mode valid           in_ready_o  accepting operands (IDLE)
//   signed_i     1 = two's complement operands a_i, b_i  multiplicand / multiplier
//   out_valid_o  product valid (DONE)          out_ready_i consumer takes product
//   p_o          2*DATA_WIDTH product, held until the next product completes
//   busy_o       multiplication in progress (BUSY)
module mul_seq_nbit #(
  parameter int DATA_WIDTH     = 16,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic                      signed_i,
  input  logic [DATA_WIDTH-1:0]     a_i,
  input  logic [DATA_WIDTH-1:0]     b_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [2*DATA_WIDTH-1:0]   p_o,
  output logic                      busy_o
);

  localparam int N     = DATA_WIDTH;
  localparam int BPC   = BITS_PER_CYCLE;
  localparam int L     = N / BPC;
  localparam int PW    = 2 * N;
  localparam int PPW   = N + BPC;
  localparam int CNT_W = (L > 1) ? $clog2(L) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(L - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [N-1:0]     a_mag_q, a_mag_d;
  logic [N-1:0]     b_mag_q, b_mag_d;
  logic             neg_q, neg_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [PW-1:0]    p_q, p_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             a_neg, b_neg;
  logic [N-1:0]     a_mag_in, b_mag_in;
  logic [PPW-1:0]   pp_terms [BPC];
  logic [PPW-1:0]   pp;
  logic [PW-1:0]    acc_sum;

  // Operand magnitudes. -2^(N-1) negates to itself, which read as unsigned is
  // exactly its magnitude, so N bits are enough.
  assign a_neg    = signed_i & a_i[N-1];
  assign b_neg    = signed_i & b_i[N-1];
  assign a_mag_in = a_neg ? -a_i : a_i;
  assign b_mag_in = b_neg ? -b_i : b_i;

  // One shifted copy of |a| per multiplier bit consumed this cycle. b_mag_q is
  // shifted down each BUSY cycle, so its low BPC bits are always the next chunk.
  genvar gi;
  generate
    for (gi = 0; gi < BPC; gi++) begin : g_pp
      assign pp_terms[gi] = b_mag_q[gi] ? (PPW'(a_mag_q) << gi) : '0;
    end
  endgenerate

  always_comb begin
    pp = '0;
    for (int i = 0; i < BPC; i++) begin
      pp = pp + pp_terms[i];
    end
    // Chunk k of b carries weight 2^(k*BPC).
    acc_sum = acc_q + (PW'(pp) << (cnt_q * BPC));
  end

  always_comb begin
    state_d = state_q;
    a_mag_d = a_mag_q;
    b_mag_d = b_mag_q;
    neg_d   = neg_q;
    acc_d   = acc_q;
    p_d     = p_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid_i) begin
          a_mag_d = a_mag_in;
          b_mag_d = b_mag_in;
          neg_d   = a_neg ^ b_neg;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        acc_d   = acc_sum;
        b_mag_d = b_mag_q >> BPC;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          p_d     = neg_q ? -acc_sum : acc_sum;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      a_mag_q <= '0;
      b_mag_q <= '0;
      neg_q   <= 1'b0;
      acc_q   <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_mag_q <= a_mag_d;
      b_mag_q <= b_mag_d;
      neg_q   <= neg_d;
      acc_q   <= acc_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready_o  = (state_q == S_IDLE);
  assign busy_o      = (state_q == S_BUSY);
  assign out_valid_o = (state_q == S_DONE);
  assign p_o         = p_q;

endmodule

// File: tb/tb_mul_seq_nbit.sv
// Testbench for mul_seq_nbit. Four instances run side by side:
//   cfg0: N=8,  BPC=1  directed cases (corner values, backpressure, reset mid-op)
//   cfg1: N=16, BPC=1  random vectors
//   cfg2: N=16, BPC=2  random vectors
//   cfg3: N=16, BPC=4  random vectors
// Each instance has a driver that pushes the expected product when it issues
// operands, and a monitor that tracks the expected handshake timing and pops and
// compares whenever a product is handed over.
module tb_mul_seq_nbit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(int cfg, string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL cfg%0d %s: got 0x%0h, expected 0x%0h", cfg, name, act, exp);
    end
  endtask

  task automatic fail_now(int cfg, string name);
    n_tests++;
    n_fail++;
    $display("FAIL cfg%0d %s: bound expired", cfg, name);
  endtask

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_cfg
      localparam int N    = (gi == 0) ? 8 : 16;
      localparam int BPC  = (gi == 3) ? 4 : ((gi == 2) ? 2 : 1);
      localparam int L    = N / BPC;
      localparam int NVEC = 2000;

      logic           rst_n     = 1'b0;
      logic           in_valid  = 1'b0;
      logic           sgn       = 1'b0;
      logic           out_ready = 1'b0;
      logic [N-1:0]   a_in      = '0;
      logic [N-1:0]   b_in      = '0;
      logic           in_ready, out_valid, busy;
      logic [2*N-1:0] p_out;
      logic [2*N-1:0] exp_q [$];
      bit             done_f    = 1'b0;

      mul_seq_nbit #(
        .DATA_WIDTH    (N),
        .BITS_PER_CYCLE(BPC)
      ) u_dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .signed_i   (sgn),
        .a_i        (a_in),
        .b_i        (b_in),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .p_o        (p_out),
        .busy_o     (busy)
      );

      // Reference: integer multiply of the operands as interpreted by the mode.
      function automatic logic [2*N-1:0] ref_mul(logic s, logic [N-1:0] a, logic [N-1:0] b);
        longint va, vb, pr;
        va = s ? longint'($signed(a)) : longint'(a);
        vb = s ? longint'($signed(b)) : longint'(b);
        pr = va * vb;
        return pr[2*N-1:0];
      endfunction

      // Random operand, biased toward the extreme values.
      function automatic logic [N-1:0] pick();
        logic [N-1:0] v;
        v = N'($urandom);
        case ($urandom_range(0, 7))
          0:       v = '0;
          1:       v = {1'b1, {(N-1){1'b0}}};
          2:       v = '1;
          3:       v = {1'b0, {(N-1){1'b1}}};
          default: ;
        endcase
        return v;
      endfunction

      // Present operands, hold in_valid until accepted, return just after the
      // accept edge.
      task automatic issue(logic s, logic [N-1:0] a, logic [N-1:0] b, logic [2*N-1:0] e);
        int w;
        w        = 0;
        sgn      = s;
        a_in     = a;
        b_in     = b;
        in_valid = 1'b1;
        exp_q.push_back(e);
        @(negedge clk);
        while (!in_ready && w < 200) begin
          @(negedge clk);
          w++;
        end
        if (!in_ready) fail_now(gi, "issue_timeout");
        @(posedge clk);
        #1;
        in_valid = 1'b0;
      endtask

      task automatic drain();
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 500) begin
          @(posedge clk);
          #1;
          w++;
        end
        if (exp_q.size() != 0) fail_now(gi, "drain_timeout");
        @(posedge clk);
        #1;
      endtask

      // Monitor: tracks when the block should be idle, busy or holding a
      // product, and compares the handed-over product with the queue head.
      initial begin : mon
        int             t;
        int             acc_t;
        int             ntx;
        bit             inflight;
        bit             holding;
        bit             hold_seen;
        bit             exp_ready;
        logic [2*N-1:0] hold_p;
        t = 0; acc_t = 0; ntx = 0;
        inflight = 1'b0; holding = 1'b0; hold_seen = 1'b0;
        hold_p = '0;
        forever begin
          @(negedge clk);
          if (!rst_n) begin
            exp_q.delete();
            inflight = 1'b0;
            holding  = 1'b0;
            check(gi, "rst_in_ready", 64'(in_ready), 64'h1);
            check(gi, "rst_out_valid", 64'(out_valid), 64'h0);
            check(gi, "rst_busy", 64'(busy), 64'h0);
            check(gi, "rst_p", 64'(p_out), 64'h0);
          end else begin
            t++;
            if (inflight && (t - acc_t == L)) begin
              inflight  = 1'b0;
              holding   = 1'b1;
              hold_seen = 1'b0;
            end
            exp_ready = !inflight && !holding;
            check(gi, "busy", 64'(busy), 64'(inflight));
            check(gi, "out_valid", 64'(out_valid), 64'(holding));
            check(gi, "in_ready", 64'(in_ready), 64'(exp_ready));
            if (holding) begin
              if (hold_seen) check(gi, "p_hold", 64'(p_out), 64'(hold_p));
              hold_p    = p_out;
              hold_seen = 1'b1;
              if (out_ready) begin
                if (exp_q.size() == 0) begin
                  fail_now(gi, "unexpected_product");
                end else begin
                  check(gi, "product", 64'(p_out), 64'(exp_q.pop_front()));
                  ntx++;
                  $display("[TB] cfg%0d txn %0d p=0x%0h", gi, ntx, p_out);
                end
                holding = 1'b0;
              end
            end else if (in_valid && exp_ready) begin
              acc_t    = t + 1;
              inflight = 1'b1;
            end
          end
        end
      end

      if (gi == 0) begin : g_dir
        initial begin
          int w;
          repeat (3) @(posedge clk);
          #1;
          rst_n     = 1'b1;
          out_ready = 1'b1;

          issue(1'b0, 8'hFF, 8'hFF, 16'hFE01);
          issue(1'b1, 8'hFF, 8'h02, 16'hFFFE);
          issue(1'b1, 8'h80, 8'h80, 16'h4000);
          issue(1'b1, 8'h80, 8'h7F, 16'hC080);
          issue(1'b0, 8'hFF, 8'h02, 16'h01FE);
          issue(1'b1, 8'h00, 8'h81, 16'h0000);
          drain();

          // Backpressure: product must hold and new operands must be ignored.
          out_ready = 1'b0;
          issue(1'b0, 8'h12, 8'h11, 16'h0132);
          w = 0;
          while (!out_valid && w < 100) begin
            @(posedge clk);
            #1;
            w++;
          end
          if (!out_valid) fail_now(gi, "bp_valid_timeout");
          for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            sgn      = 1'($urandom);
            a_in     = N'($urandom);
            b_in     = N'($urandom);
            @(posedge clk);
            #1;
            check(gi, "bp_in_ready", 64'(in_ready), 64'h0);
            check(gi, "bp_p", 64'(p_out), 64'h0132);
          end
          in_valid  = 1'b0;
          out_ready = 1'b1;
          @(posedge clk);
          #1;
          check(gi, "bp_release_ready", 64'(in_ready), 64'h1);
          check(gi, "bp_release_valid", 64'(out_valid), 64'h0);
          check(gi, "bp_p_kept", 64'(p_out), 64'h0132);

          // Reset in the third BUSY cycle abandons the operation.
          issue(1'b0, 8'h12, 8'h34, 16'h03A8);
          @(posedge clk);
          @(posedge clk);
          #2;
          rst_n = 1'b0;
          #1;
          check(gi, "midrst_in_ready", 64'(in_ready), 64'h1);
          check(gi, "midrst_out_valid", 64'(out_valid), 64'h0);
          check(gi, "midrst_busy", 64'(busy), 64'h0);
          check(gi, "midrst_p", 64'(p_out), 64'h0);
          repeat (2) @(posedge clk);
          #1;
          rst_n = 1'b1;
          issue(1'b0, 8'h03, 8'h05, 16'h000F);
          drain();

          // Operands changing during BUSY must not disturb the result.
          issue(1'b0, 8'h10, 8'h10, 16'h0100);
          for (int k = 0; k < 10; k++) begin
            sgn  = 1'($urandom);
            a_in = N'($urandom);
            b_in = N'($urandom);
            @(posedge clk);
            #1;
          end
          drain();
          done_f = 1'b1;
        end
      end else begin : g_rand
        initial begin
          logic         s;
          logic [N-1:0] a;
          logic [N-1:0] b;
          repeat (3) @(posedge clk);
          #1;
          rst_n = 1'b1;
          for (int i = 0; i < NVEC; i++) begin
            s = 1'($urandom);
            a = pick();
            b = pick();
            issue(s, a, b, ref_mul(s, a, b));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
          end
          drain();
          done_f = 1'b1;
        end

        initial begin
          forever begin
            @(posedge clk);
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
          end
        end
      end
    end
  endgenerate

  initial begin
    int w;
    w = 0;
    while (!(g_cfg[0].done_f && g_cfg[1].done_f && g_cfg[2].done_f && g_cfg[3].done_f)
           && w < 90000) begin
      @(posedge clk);
      w++;
    end
    if (w >= 90000) fail_now(-1, "global_timeout");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
